// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for prog_clock_divider. The master drives the ratio/mode requests.
// The slave is the divider, which returns the counter state and the divided outputs.
interface prog_clock_divider_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic [WIDTH-1:0] div_value;
  logic             mode_in;
  logic             div_load;
  logic             pending;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             clock_out;

  modport master (
    output enable, div_value, mode_in, div_load,
    input  pending, count, tick, clock_out
  );

  modport slave (
    input  enable, div_value, mode_in, div_load,
    output pending, count, tick, clock_out
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with a registered tick and a divided clock.
// Ratio/mode requests are shadowed and only take effect on a period boundary.
module prog_clock_divider #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 500,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  prog_clock_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] count_p1, act_n, sh_n;
  logic             act_mode, sh_mode, pending_p1, tick_p1, clk_out_p1;

  logic [WIDTH-1:0] nxt_count, nxt_n, nxt_sh_n, req_n;
  logic             nxt_mode, nxt_sh_mode, nxt_pending, nxt_tick, nxt_clk_out;
  logic             wrap, load_now;

  // Ratios below 2 cannot produce a tick followed by a non-tick cycle, so they saturate to 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  always_comb begin
    req_n       = clamp_div(bus.div_value);
    wrap        = bus.enable && (count_p1 == act_n - WIDTH'(1));
    load_now    = bus.div_load && (!bus.enable || wrap);
    nxt_n       = act_n;
    nxt_mode    = act_mode;
    nxt_sh_n    = sh_n;
    nxt_sh_mode = sh_mode;
    nxt_pending = pending_p1;
    nxt_count   = count_p1;
    nxt_tick    = 1'b0;
    nxt_clk_out = clk_out_p1;

    if (load_now) begin
      nxt_n       = req_n;
      nxt_mode    = bus.mode_in;
      nxt_pending = 1'b0;
    end else if (bus.div_load) begin
      nxt_sh_n    = req_n;
      nxt_sh_mode = bus.mode_in;
      nxt_pending = 1'b1;
    end else if (wrap && pending_p1) begin
      nxt_n       = sh_n;
      nxt_mode    = sh_mode;
      nxt_pending = 1'b0;
    end

    if (bus.enable) begin
      nxt_count   = wrap ? '0 : count_p1 + WIDTH'(1);
      nxt_tick    = wrap;
      // Square output is evaluated against the ratio that governs the upcoming period.
      nxt_clk_out = nxt_mode ? (nxt_count < (nxt_n >> 1)) : wrap;
    end else if (bus.div_load) begin
      nxt_count   = '0;
    end
  end

  // Stage p1: all architectural state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_p1   <= '0;
      act_n      <= RST_DIV;
      act_mode   <= DEFAULT_MODE;
      sh_n       <= RST_DIV;
      sh_mode    <= DEFAULT_MODE;
      pending_p1 <= 1'b0;
      tick_p1    <= 1'b0;
      clk_out_p1 <= 1'b0;
    end else begin
      count_p1   <= nxt_count;
      act_n      <= nxt_n;
      act_mode   <= nxt_mode;
      sh_n       <= nxt_sh_n;
      sh_mode    <= nxt_sh_mode;
      pending_p1 <= nxt_pending;
      tick_p1    <= nxt_tick;
      clk_out_p1 <= nxt_clk_out;
    end
  end

  assign bus.count     = count_p1;
  assign bus.pending   = pending_p1;
  assign bus.tick      = tick_p1;
  assign bus.clock_out = clk_out_p1;

endmodule
